// File: rtl/mp_reg_file_if.sv
// Register-file access bundle: read ports, write ports, issue strobe and scoreboard view.
interface mp_reg_file_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NREG = 32,
    parameter int unsigned NRD  = 2,
    parameter int unsigned NWR  = 2
);
    localparam int unsigned AW = $clog2(NREG);

    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_pend;
    logic [NWR-1:0]      wr_en;
    logic [NWR*AW-1:0]   wr_addr;
    logic [NWR*XLEN-1:0] wr_data;
    logic                iss_en;
    logic [AW-1:0]       iss_addr;
    logic [NREG-1:0]     pend_vec;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
        input  rd_data, rd_pend, pend_vec
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
        output rd_data, rd_pend, pend_vec
    );
endinterface

// File: rtl/mp_reg_file.sv
// Multi-port register file with optional write-to-read forwarding and a per-register
// pending scoreboard. Register 0 is hard-wired to zero and is never pending.
module mp_reg_file #(
    parameter int unsigned     XLEN    = 32,
    parameter int unsigned     NREG    = 32,
    parameter int unsigned     NRD     = 2,
    parameter int unsigned     NWR     = 2,
    parameter int unsigned     BYPASS  = 1,
    parameter int unsigned     SP_IDX  = 2,
    parameter logic [XLEN-1:0] SP_INIT = XLEN'(32'h0000_FFFC)
) (
    input  logic          clk,
    input  logic          rst,
    mp_reg_file_if.slave  bus
);
    localparam int unsigned AW = $clog2(NREG);

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic [NREG-1:0] pend_q;
    logic [NREG-1:0] pend_d;

    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rdata;
    logic            hit;

    // Write resolution: later ports overwrite earlier ones, so the highest index wins.
    always_comb begin
        regs_d = regs_q;
        for (int p = 0; p < int'(NWR); p++) begin
            if (bus.wr_en[p] && (bus.wr_addr[p*AW +: AW] != '0)) begin
                regs_d[bus.wr_addr[p*AW +: AW]] = bus.wr_data[p*XLEN +: XLEN];
            end
        end
        regs_d[0] = '0;
    end

    // Scoreboard: writes clear, issue sets afterwards so a same-cycle issue wins.
    always_comb begin
        pend_d = pend_q;
        for (int p = 0; p < int'(NWR); p++) begin
            if (bus.wr_en[p]) begin
                pend_d[bus.wr_addr[p*AW +: AW]] = 1'b0;
            end
        end
        if (bus.iss_en) begin
            pend_d[bus.iss_addr] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs_q[AW'(i)] <= (i == SP_IDX) ? SP_INIT : '0;
            end
            pend_q <= '0;
        end else begin
            regs_q <= regs_d;
            pend_q <= pend_d;
        end
    end

    // Zero-latency read ports with optional forwarding from the current write ports.
    always_comb begin
        bus.rd_data = '0;
        bus.rd_pend = '0;
        ra          = '0;
        rdata       = '0;
        hit         = 1'b0;
        for (int p = 0; p < int'(NRD); p++) begin
            ra    = bus.rd_addr[p*AW +: AW];
            rdata = (ra == '0) ? '0 : regs_q[ra];
            hit   = 1'b0;
            if (BYPASS != 0) begin
                for (int w = 0; w < int'(NWR); w++) begin
                    if (bus.wr_en[w] && (bus.wr_addr[w*AW +: AW] == ra) && (ra != '0)) begin
                        rdata = bus.wr_data[w*XLEN +: XLEN];
                        hit   = 1'b1;
                    end
                end
            end
            bus.rd_data[p*XLEN +: XLEN] = rdata;
            bus.rd_pend[p]              = pend_q[ra] & ~hit;
        end
    end

    assign bus.pend_vec = pend_q;

endmodule

// File: tb/tb_mp_reg_file.sv
// Bench for mp_reg_file: a forwarding and a non-forwarding instance share one stimulus
// stream and are compared against an array-based model of the register file.
module tb_mp_reg_file;
    localparam int unsigned XLEN = 32;
    localparam int unsigned NREG = 32;
    localparam int unsigned NRD  = 2;
    localparam int unsigned NWR  = 2;
    localparam int unsigned AW   = 5;

    logic clk;
    logic rst;

    mp_reg_file_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)) ifa ();
    mp_reg_file_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)) ifb ();

    assign ifb.rd_addr  = ifa.rd_addr;
    assign ifb.wr_en    = ifa.wr_en;
    assign ifb.wr_addr  = ifa.wr_addr;
    assign ifb.wr_data  = ifa.wr_data;
    assign ifb.iss_en   = ifa.iss_en;
    assign ifb.iss_addr = ifa.iss_addr;

    mp_reg_file #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .BYPASS(1)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa.slave)
    );

    mp_reg_file #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .BYPASS(0)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [XLEN-1:0] m_reg [NREG];
    logic [NREG-1:0] m_pend;
    int checks = 0;
    int passed = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic m_reset();
        for (int i = 0; i < int'(NREG); i++) m_reg[i] = '0;
        m_reg[2] = 32'h0000_FFFC;
        m_pend   = '0;
    endtask

    // Architectural update at a rising edge, straight from the register-file rules.
    task automatic m_update();
        logic [AW-1:0] a;
        for (int w = 0; w < int'(NWR); w++) begin
            a = ifa.wr_addr[w*AW +: AW];
            if (ifa.wr_en[w] && a != 0) m_reg[a] = ifa.wr_data[w*XLEN +: XLEN];
        end
        for (int w = 0; w < int'(NWR); w++) begin
            a = ifa.wr_addr[w*AW +: AW];
            if (ifa.wr_en[w]) m_pend[a] = 1'b0;
        end
        if (ifa.iss_en && ifa.iss_addr != 0) m_pend[ifa.iss_addr] = 1'b1;
    endtask

    task automatic check_all();
        logic [AW-1:0]   a;
        logic [XLEN-1:0] stored;
        logic [XLEN-1:0] fwd;
        logic            hit;
        for (int p = 0; p < int'(NRD); p++) begin
            a      = ifa.rd_addr[p*AW +: AW];
            stored = (a == 0) ? '0 : m_reg[a];
            hit    = 1'b0;
            fwd    = '0;
            for (int w = 0; w < int'(NWR); w++) begin
                if (ifa.wr_en[w] && ifa.wr_addr[w*AW +: AW] == a && a != 0) begin
                    hit = 1'b1;
                    fwd = ifa.wr_data[w*XLEN +: XLEN];
                end
            end
            chk("rd_data_byp",   64'(ifa.rd_data[p*XLEN +: XLEN]), 64'(hit ? fwd : stored));
            chk("rd_data_nobyp", 64'(ifb.rd_data[p*XLEN +: XLEN]), 64'(stored));
            chk("rd_pend_byp",   64'(ifa.rd_pend[p]), 64'(m_pend[a] & ~hit));
            chk("rd_pend_nobyp", 64'(ifb.rd_pend[p]), 64'(m_pend[a]));
        end
        chk("pend_vec_byp",   64'(ifa.pend_vec), 64'(m_pend));
        chk("pend_vec_nobyp", 64'(ifb.pend_vec), 64'(m_pend));
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) m_update();
        @(negedge clk);
    endtask

    task automatic cycle();
        settle();
        check_all();
        tick();
    endtask

    task automatic idle();
        ifa.wr_en    = '0;
        ifa.iss_en   = 1'b0;
        ifa.iss_addr = '0;
    endtask

    task automatic randomize_inputs();
        ifa.wr_en    = 2'($urandom);
        ifa.wr_addr  = {5'($urandom_range(0, 11)), 5'($urandom_range(0, 11))};
        ifa.wr_data  = {$urandom, $urandom};
        ifa.iss_en   = 1'($urandom_range(0, 1));
        ifa.iss_addr = 5'($urandom_range(0, 11));
        ifa.rd_addr  = {5'($urandom_range(0, 11)), 5'($urandom_range(0, 11))};
        if ($urandom_range(0, 1) == 1) ifa.rd_addr[AW-1:0] = ifa.wr_addr[AW-1:0];
    endtask

    initial begin
        rst         = 1'b1;
        ifa.rd_addr = '0;
        ifa.wr_addr = '0;
        ifa.wr_data = '0;
        idle();
        m_reset();
        @(negedge clk);

        // Reset values
        ifa.rd_addr = {5'd5, 5'd2};
        settle();
        check_all();
        chk("rst_sp_value", 64'(ifa.rd_data[31:0]), 64'h0000_FFFC);
        chk("rst_other_zero", 64'(ifa.rd_data[63:32]), 64'h0);
        chk("rst_pend_vec", 64'(ifa.pend_vec), 64'h0);
        tick();
        rst = 1'b0;

        // Forwarding versus stored-only read
        ifa.wr_en   = 2'b01;
        ifa.wr_addr = {5'd0, 5'd5};
        ifa.wr_data = {32'h0, 32'hDEAD_BEEF};
        ifa.rd_addr = {5'd0, 5'd5};
        settle();
        check_all();
        chk("byp_same_cycle", 64'(ifa.rd_data[31:0]), 64'hDEAD_BEEF);
        chk("nobyp_stale", 64'(ifb.rd_data[31:0]), 64'h0);
        tick();
        idle();
        settle();
        check_all();
        chk("nobyp_next_cycle", 64'(ifb.rd_data[31:0]), 64'hDEAD_BEEF);
        tick();

        // Same-address write conflict
        ifa.wr_en   = 2'b11;
        ifa.wr_addr = {5'd7, 5'd7};
        ifa.wr_data = {32'h2222, 32'h1111};
        ifa.rd_addr = {5'd7, 5'd7};
        settle();
        check_all();
        chk("conflict_byp", 64'(ifa.rd_data[31:0]), 64'h2222);
        tick();
        idle();
        settle();
        check_all();
        chk("conflict_stored", 64'(ifb.rd_data[31:0]), 64'h2222);
        tick();

        // Register zero ignores writes and issues
        ifa.wr_en    = 2'b01;
        ifa.wr_addr  = {5'd0, 5'd0};
        ifa.wr_data  = {32'h0, 32'hFFFF_FFFF};
        ifa.iss_en   = 1'b1;
        ifa.iss_addr = 5'd0;
        ifa.rd_addr  = {5'd0, 5'd0};
        settle();
        check_all();
        chk("reg0_byp_read", 64'(ifa.rd_data[31:0]), 64'h0);
        tick();
        idle();
        settle();
        check_all();
        chk("reg0_not_pending", 64'(ifa.pend_vec[0]), 64'h0);
        chk("reg0_read", 64'(ifb.rd_data[31:0]), 64'h0);
        tick();

        // Scoreboard set / set-wins / clear
        ifa.iss_en   = 1'b1;
        ifa.iss_addr = 5'd9;
        ifa.rd_addr  = {5'd9, 5'd9};
        cycle();
        idle();
        settle();
        check_all();
        chk("pend9_set", 64'(ifa.pend_vec[9]), 64'h1);
        tick();
        ifa.wr_en    = 2'b01;
        ifa.wr_addr  = {5'd0, 5'd9};
        ifa.wr_data  = {32'h0, 32'h0000_ABCD};
        ifa.iss_en   = 1'b1;
        ifa.iss_addr = 5'd9;
        settle();
        check_all();
        chk("pend9_fwd_clear", 64'(ifa.rd_pend[0]), 64'h0);
        chk("pend9_nofwd", 64'(ifb.rd_pend[0]), 64'h1);
        tick();
        idle();
        settle();
        check_all();
        chk("pend9_set_wins", 64'(ifa.pend_vec[9]), 64'h1);
        tick();
        ifa.wr_en   = 2'b01;
        ifa.wr_addr = {5'd0, 5'd9};
        settle();
        check_all();
        chk("pend9_write_cycle", 64'(ifa.rd_pend[0]), 64'h0);
        tick();
        idle();
        settle();
        check_all();
        chk("pend9_cleared", 64'(ifa.pend_vec[9]), 64'h0);
        tick();

        // Randomized traffic with a mid-run reset that sweeps every address
        for (int i = 0; i < 400; i++) begin
            randomize_inputs();
            if (i == 200) begin
                rst = 1'b1;
                m_reset();
                for (int a = 0; a < int'(NREG); a++) begin
                    ifa.rd_addr = {5'(a ^ 1), 5'(a)};
                    cycle();
                    randomize_inputs();
                end
                rst = 1'b0;
            end
            cycle();
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
